// File: rtl/cpu_mem_responder.sv
// Word-addressed RAM responder for the CPU fetch and load/store valid/ready channels.
// Loads and fetches return after a fixed LATENCY; stores complete in the accept cycle.
module cpu_mem_responder #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC,
  input  logic              Inst_Req_Valid,
  output logic              Inst_Req_Ready,
  output logic [31:0]       Instruction,
  output logic              Inst_Valid,
  input  logic              Inst_Ready,
  input  logic [31:0]       Address,
  input  logic              MemWrite,
  input  logic [31:0]       Write_data,
  input  logic [3:0]        Write_strb,
  input  logic              MemRead,
  output logic              Mem_Req_Ready,
  output logic [31:0]       Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data
);

  typedef enum logic [2:0] {StIdle, StWaitI, StWaitD, StRespI, StRespD} state_e;

  localparam logic [3:0] LatCnt = 4'(LATENCY);

  state_e            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_inst;
  logic              r_inst_vld;
  logic [31:0]       r_rdata;
  logic              r_rdata_vld;
  logic [31:0]       r_mem [2**ADDR_W];

  logic              w_idle;
  logic              w_store;
  logic              w_load;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_d_idx;
  logic [ADDR_W-1:0] w_i_idx;
  logic              w_unused;

  assign w_d_idx = Address[ADDR_W+1:2];
  assign w_i_idx = PC[ADDR_W+1:2];
  // Byte offset and high address bits are ignored so addresses wrap silently.
  assign w_unused = ^{PC[31:ADDR_W+2], PC[1:0], Address[31:ADDR_W+2], Address[1:0]};

  assign w_idle         = (r_state == StIdle);
  assign Mem_Req_Ready  = w_idle && !load_en;
  assign Inst_Req_Ready = w_idle && !load_en && !MemRead && !MemWrite;

  // A simultaneous MemRead+MemWrite is a store only.
  assign w_store = Mem_Req_Ready && MemWrite;
  assign w_load  = Mem_Req_Ready && MemRead && !MemWrite;
  assign w_fetch = Inst_Req_Ready && Inst_Req_Valid;

  assign Instruction     = r_inst;
  assign Inst_Valid      = r_inst_vld;
  assign Read_data       = r_rdata;
  assign Read_data_Valid = r_rdata_vld;

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end else if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (Write_strb[b]) begin
          r_mem[w_d_idx][8*b +: 8] <= Write_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_idx       <= '0;
      r_inst      <= 32'd0;
      r_inst_vld  <= 1'b0;
      r_rdata     <= 32'd0;
      r_rdata_vld <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_load) begin
            r_idx <= w_d_idx;
            r_cnt <= LatCnt;
            if (LATENCY == 0) begin
              r_rdata     <= r_mem[w_d_idx];
              r_rdata_vld <= 1'b1;
              r_state     <= StRespD;
            end else begin
              r_state <= StWaitD;
            end
          end else if (w_fetch) begin
            r_idx <= w_i_idx;
            r_cnt <= LatCnt;
            if (LATENCY == 0) begin
              r_inst     <= r_mem[w_i_idx];
              r_inst_vld <= 1'b1;
              r_state    <= StRespI;
            end else begin
              r_state <= StWaitI;
            end
          end
        end
        StWaitD: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rdata     <= r_mem[r_idx];
            r_rdata_vld <= 1'b1;
            r_state     <= StRespD;
          end
        end
        StWaitI: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_inst     <= r_mem[r_idx];
            r_inst_vld <= 1'b1;
            r_state    <= StRespI;
          end
        end
        StRespD: begin
          if (Read_data_Ready) begin
            r_rdata_vld <= 1'b0;
            r_state     <= StIdle;
          end
        end
        StRespI: begin
          if (Inst_Ready) begin
            r_inst_vld <= 1'b0;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench: one responder at LATENCY=2 (a_*) and one at LATENCY=0 (z_*),
// sharing clock, reset, address/data buses and the preload port.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0, addr = '0, wdata = '0, load_data = '0;
  logic [3:0]  wstrb = '0;
  logic        load_en = 1'b0;
  logic [11:0] load_addr = '0;

  logic        a_iv = 0, a_ir = 0, a_mw = 0, a_mr = 0, a_rr = 0;
  logic        a_irdy, a_ivld, a_mrdy, a_rvld;
  logic [31:0] a_inst, a_rdata;
  logic        z_iv = 0, z_ir = 0, z_mw = 0, z_mr = 0, z_rr = 0;
  logic        z_irdy, z_ivld, z_mrdy, z_rvld;
  logic [31:0] z_inst, z_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.ADDR_W(12), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst), .PC(pc), .Inst_Req_Valid(a_iv), .Inst_Req_Ready(a_irdy),
    .Instruction(a_inst), .Inst_Valid(a_ivld), .Inst_Ready(a_ir), .Address(addr),
    .MemWrite(a_mw), .Write_data(wdata), .Write_strb(wstrb), .MemRead(a_mr),
    .Mem_Req_Ready(a_mrdy), .Read_data(a_rdata), .Read_data_Valid(a_rvld),
    .Read_data_Ready(a_rr), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  cpu_mem_responder #(.ADDR_W(12), .LATENCY(0)) u_z (
    .clk(clk), .rst(rst), .PC(pc), .Inst_Req_Valid(z_iv), .Inst_Req_Ready(z_irdy),
    .Instruction(z_inst), .Inst_Valid(z_ivld), .Inst_Ready(z_ir), .Address(addr),
    .MemWrite(z_mw), .Write_data(wdata), .Write_strb(wstrb), .MemRead(z_mr),
    .Mem_Req_Ready(z_mrdy), .Read_data(z_rdata), .Read_data_Valid(z_rvld),
    .Read_data_Ready(z_rr), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] wa, input logic [31:0] wd);
    load_en   = 1'b1;
    load_addr = wa;
    load_data = wd;
    step();
    load_en = 1'b0;
  endtask

  // Load on the LATENCY=2 instance with Read_data_Ready held high.
  task automatic load_a(input logic [31:0] av, input logic [31:0] exp, input string tag);
    addr = av;
    a_mr = 1'b1;
    a_rr = 1'b1;
    #1 chk({tag, "_acc"}, a_mrdy, 1);
    step();
    a_mr = 1'b0;
    chk({tag, "_w1"}, a_rvld, 0);
    step();
    chk({tag, "_w2"}, a_rvld, 0);
    step();
    chk({tag, "_vld"}, a_rvld, 1);
    chk({tag, "_data"}, a_rdata, exp);
    step();
    chk({tag, "_done"}, a_rvld, 0);
    a_rr = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_ivld", a_ivld, 0);
    chk("rst_rvld", a_rvld, 0);
    chk("rst_inst", a_inst, 0);
    chk("rst_rdata", a_rdata, 0);
    rst = 1'b1;
    step();
    chk("rel_mrdy", a_mrdy, 1);
    chk("rel_irdy", a_irdy, 1);

    load_en   = 1'b1;
    load_addr = 12'h010;
    load_data = 32'hDEADBEEF;
    #1 chk("ld_blk_mrdy", a_mrdy, 0);
    chk("ld_blk_irdy", a_irdy, 0);
    step();
    load_en = 1'b0;
    preload(12'h020, 32'h11223344);
    preload(12'h000, 32'hCAFE0000);
    preload(12'h005, 32'h55667788);

    // Fetch with 3 cycles of Inst_Ready low
    pc   = 32'h40;
    a_iv = 1'b1;
    #1 chk("f_acc", a_irdy, 1);
    step();
    a_iv = 1'b0;
    chk("f_w1_vld", a_ivld, 0);
    chk("f_w1_irdy", a_irdy, 0);
    step();
    chk("f_w2_vld", a_ivld, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("f_hold_vld", a_ivld, 1);
      chk("f_hold_data", a_inst, 32'hDEADBEEF);
      if (i == 3) a_ir = 1'b1;
      step();
    end
    a_ir = 1'b0;
    chk("f_done_vld", a_ivld, 0);
    chk("f_idle_irdy", a_irdy, 1);

    // Byte-strobed store then load
    addr  = 32'h82;
    wstrb = 4'b0100;
    wdata = 32'h00AA0000;
    a_mw  = 1'b1;
    #1 chk("st_mrdy", a_mrdy, 1);
    step();
    a_mw = 1'b0;
    chk("st_idle", a_mrdy, 1);
    load_a(32'h80, 32'h11AA3344, "ld_strb");

    addr  = 32'h80;
    wstrb = 4'b0000;
    wdata = 32'hFFFFFFFF;
    a_mw  = 1'b1;
    step();
    a_mw = 1'b0;
    load_a(32'h80, 32'h11AA3344, "ld_strb0");

    // Data request wins over simultaneous fetch
    addr = 32'h14;
    pc   = 32'h80;
    a_mr = 1'b1;
    a_iv = 1'b1;
    a_rr = 1'b1;
    a_ir = 1'b1;
    #1 chk("pri_mrdy", a_mrdy, 1);
    chk("pri_irdy", a_irdy, 0);
    step();
    a_mr = 1'b0;
    chk("pri_n1_irdy", a_irdy, 0);
    step();
    step();
    chk("pri_rvld", a_rvld, 1);
    chk("pri_rdata", a_rdata, 32'h55667788);
    step();
    chk("pri_f_acc", a_irdy, 1);
    chk("pri_rvld_off", a_rvld, 0);
    step();
    a_iv = 1'b0;
    chk("pri_f_w1", a_ivld, 0);
    step();
    step();
    chk("pri_ivld", a_ivld, 1);
    chk("pri_inst", a_inst, 32'h11AA3344);
    step();
    chk("pri_ivld_off", a_ivld, 0);
    a_ir = 1'b0;
    a_rr = 1'b0;

    // LATENCY=0 with wrapping address
    addr = 32'h0000_4000;
    z_mr = 1'b1;
    #1 chk("z_acc", z_mrdy, 1);
    step();
    z_mr = 1'b0;
    chk("z_lat0_vld", z_rvld, 1);
    chk("z_wrap_data", z_rdata, 32'hCAFE0000);
    step();
    chk("z_hold_vld", z_rvld, 1);
    chk("z_resp_mrdy", z_mrdy, 0);

    // Asynchronous reset in RESP_D
    rst = 1'b0;
    #1 chk("z_rst_vld", z_rvld, 0);
    chk("z_rst_data", z_rdata, 0);
    chk("a_rst_rdata", a_rdata, 0);
    step();
    rst = 1'b1;
    #1 chk("z_rel_mrdy", z_mrdy, 1);
    chk("z_rel_irdy", z_irdy, 1);
    step();
    chk("z_rel_vld1", z_rvld, 0);
    step();
    chk("z_rel_vld2", z_rvld, 0);

    // load_en blocks acceptance for one cycle only
    load_en   = 1'b1;
    load_addr = 12'h030;
    load_data = 32'h0BADF00D;
    addr      = 32'hC0;
    a_mr      = 1'b1;
    a_rr      = 1'b1;
    #1 chk("len_blk", a_mrdy, 0);
    step();
    load_en = 1'b0;
    #1 chk("len_next_acc", a_mrdy, 1);
    step();
    a_mr = 1'b0;
    chk("len_w1", a_rvld, 0);
    step();
    step();
    chk("len_vld", a_rvld, 1);
    chk("len_data", a_rdata, 32'h0BADF00D);
    step();
    chk("len_done", a_rvld, 0);
    a_rr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
